// File: rtl/data_axi_bridge_pkg.sv
// Shared AXI bridge definitions: bridge state encoding, response codes, fixed AXI fields.
// No logic and no latency; the fixed fields are consumed by the SoC-level wrapper.
// No flow control of its own; the handshake rules live in the bridges that import it.
package axi_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } busState_t;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [3:0] AXI_ID         = 4'd1;
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [2:0] AXI_SIZE       = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // kseg0 (3'b100) and kseg1 (3'b101) are direct-mapped windows onto the low 512 MiB.
  function automatic logic isUnmapped(input logic [2:0] topBits);
    return (topBits == 3'b100) || (topBits == 3'b101);
  endfunction

endpackage

// File: rtl/kseg_map.sv
// Virtual-to-physical address mapper shared by the data- and instruction-side bridges.
// Purely combinational, zero latency.
// No backpressure; the address is passed straight through to the caller.
module kseg_map
  import axi_defs::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (ENABLE && isUnmapped(vaddr[31:29])) begin
      paddr[31:29] = 3'b000;
    end
  end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side bridge: turns the memory-stage SRAM-style request into one single-beat AXI4 read or write.
// Latency: 4 cycles request->DONE with a zero-wait slave (IDLE, RADDR/WREQ, RDATA/WRESP, DONE).
// Backpressure: d_stall holds the pipeline until DONE; AXI valids stay up until their ready arrives.
module data_axi_bridge
  import axi_defs::*;
#(
  parameter bit KSEG_MAP   = 1'b1,
  parameter bit RESP_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        bus_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  busState_t   state, nextState;
  logic [31:0] physAddr;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [3:0]  wenReg;
  logic        awDone, wDone;
  logic        rFire, awFire, wFire, bFire;

  kseg_map #(.ENABLE(KSEG_MAP)) uKsegMap (
    .vaddr (data_addr),
    .paddr (physAddr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        if (data_en) begin
          nextState = (data_wen == 4'b0000) ? RADDR : WREQ;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) nextState = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) nextState = DONE;
      end
      WREQ: begin
        // AW and W are independent channels; either may complete first or both together.
        awvalid = ~awDone;
        wvalid  = ~wDone;
        if ((awDone || awready) && (wDone || wready)) nextState = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) nextState = DONE;
      end
      DONE: begin
        // Holding here while the pipeline is frozen keeps the same request from being reissued.
        if (!longest_stall) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign rFire  = rvalid & rready;
  assign awFire = awvalid & awready;
  assign wFire  = wvalid & wready;
  assign bFire  = bvalid & bready;

  assign d_stall = data_en & (state != DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addrReg    <= 32'd0;
      wdataReg   <= 32'd0;
      wenReg     <= 4'd0;
      awDone     <= 1'b0;
      wDone      <= 1'b0;
      data_rdata <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      if (state == IDLE && data_en) begin
        addrReg  <= physAddr & 32'hFFFF_FFFC;
        wdataReg <= data_wdata;
        wenReg   <= data_wen;
        awDone   <= 1'b0;
        wDone    <= 1'b0;
      end
      if (awFire) awDone <= 1'b1;
      if (wFire)  wDone  <= 1'b1;
      if (rFire)  data_rdata <= rdata;
      // Error is reported alongside normal completion; the transaction is not retried.
      bus_err <= RESP_CHECK & ((rFire & (rresp != RESP_OKAY)) | (bFire & (bresp != RESP_OKAY)));
    end
  end

  assign araddr = addrReg;
  assign awaddr = addrReg;
  assign wdata  = wdataReg;
  assign wstrb  = wenReg;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: configurable-wait AXI slave plus queue scoreboard.
module tb_data_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        longest_stall, d_stall, bus_err;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  data_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .longest_stall(longest_stall), .d_stall(d_stall), .bus_err(bus_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues, filled when a request is driven.
  logic [31:0] arQ[$], awQ[$], rdQ[$];
  logic [35:0] wQ[$];
  logic        errQ[$];
  int arBeats = 0, awBeats = 0, wBeats = 0, rBeats = 0, bBeats = 0;

  // Slave configuration.
  int arWait = 0, rWait = 0, awWait = 0, wWait = 0, bWait = 0;
  logic [31:0] slvRdata = 32'd0;
  logic [1:0]  slvResp = 2'b00;

  initial begin
    int arCnt, rCnt, awCnt, wCnt, bCnt;
    arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = 32'd0; rresp = 2'b00; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin arready = (arCnt >= arWait); arCnt++; end else begin arready = 1'b0; arCnt = 0; end
      if (rready)  begin rvalid  = (rCnt >= rWait);   rCnt++;  end else begin rvalid  = 1'b0; rCnt  = 0; end
      if (awvalid) begin awready = (awCnt >= awWait); awCnt++; end else begin awready = 1'b0; awCnt = 0; end
      if (wvalid)  begin wready  = (wCnt >= wWait);   wCnt++;  end else begin wready  = 1'b0; wCnt  = 0; end
      if (bready)  begin bvalid  = (bCnt >= bWait);   bCnt++;  end else begin bvalid  = 1'b0; bCnt  = 0; end
      rdata = slvRdata; rresp = slvResp; bresp = slvResp;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks registered results one cycle later.
  bit rdPend = 0, errPend = 0, errExp = 0;
  logic [31:0] rdExp = 32'd0;
  always @(negedge clk) begin
    if (!resetn) begin
      rdPend = 0;
      errPend = 0;
    end else begin
      if (rdPend) begin chk("rdata_out", data_rdata, rdExp); rdPend = 0; end
      if (errPend) begin chk("bus_err_pulse", bus_err, errExp); errPend = 0; end
      else chk("bus_err_quiet", bus_err, 0);
      if (arvalid && arready) begin
        arBeats++;
        chk("ar_pending", arQ.size(), 1);
        if (arQ.size() > 0) chk("araddr", araddr, arQ.pop_front());
      end
      if (awvalid && awready) begin
        awBeats++;
        chk("aw_pending", awQ.size(), 1);
        if (awQ.size() > 0) chk("awaddr", awaddr, awQ.pop_front());
      end
      if (wvalid && wready) begin
        wBeats++;
        chk("w_pending", wQ.size(), 1);
        if (wQ.size() > 0) chk("wstrb_wdata", {wstrb, wdata}, wQ.pop_front());
      end
      if (rvalid && rready) begin
        rBeats++;
        if (rdQ.size() > 0) begin rdExp = rdQ.pop_front(); rdPend = 1; end
        if (errQ.size() > 0) begin errExp = errQ.pop_front(); errPend = 1; end
      end
      if (bvalid && bready) begin
        bBeats++;
        if (errQ.size() > 0) begin errExp = errQ.pop_front(); errPend = 1; end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the bridge back in IDLE.
  task automatic request(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] expAddr, input logic [31:0] rd, input logic [1:0] resp,
                         input int hold);
    int stall, expStall, ar0, aw0, w0, r0, b0;
    bit isWr;
    stall = 0;
    isWr = (wen != 4'b0000);
    ar0 = arBeats; aw0 = awBeats; w0 = wBeats; r0 = rBeats; b0 = bBeats;
    slvRdata = rd;
    slvResp = resp;
    if (isWr) begin
      awQ.push_back(expAddr);
      wQ.push_back({wen, wd});
      expStall = 1 + ((awWait > wWait) ? awWait : wWait) + 1 + bWait + 1;
    end else begin
      arQ.push_back(expAddr);
      rdQ.push_back(rd);
      expStall = 1 + arWait + 1 + rWait + 1;
    end
    errQ.push_back(resp != 2'b00);
    data_en = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wd; longest_stall = 1'b1;
    #2;
    for (int c = 0; c < 60 && d_stall; c++) begin
      stall++;
      @(posedge clk); #1;
      // The bridge must work from its captured copies, not the live inputs.
      data_wen = ~wen; data_addr = ~addr; data_wdata = ~wd;
      #2;
    end
    chk("done_dstall", d_stall, 0);
    chk("stall_cycles", stall, expStall);
    for (int h = 0; h < hold; h++) begin
      if (!isWr) chk("hold_rdata", data_rdata, rd);
      chk("hold_dstall", d_stall, 0);
      @(posedge clk); #3;
    end
    if (!isWr) chk("done_rdata", data_rdata, rd);
    longest_stall = 1'b0;
    @(posedge clk); #1;
    data_en = 1'b0;
    #1; data_en = 1'b1;
    #1; chk("back_to_idle", d_stall, 1);
    data_en = 1'b0;
    chk("ar_beats", arBeats - ar0, isWr ? 0 : 1);
    chk("r_beats", rBeats - r0, isWr ? 0 : 1);
    chk("aw_beats", awBeats - aw0, isWr ? 1 : 0);
    chk("w_beats", wBeats - w0, isWr ? 1 : 0);
    chk("b_beats", bBeats - b0, isWr ? 1 : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; data_en = 1'b0; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
    longest_stall = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rdata", data_rdata, 0);
    chk("rst_addr", araddr, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_dstall", d_stall, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait kseg1 read.
    arWait = 0; rWait = 0;
    request(4'b0000, 32'hBFC0_0104, 32'd0, 32'h1FC0_0104, 32'hDEAD_BEEF, 2'b00, 0);
    // Write with AW first, W two cycles later.
    awWait = 0; wWait = 2; bWait = 0;
    request(4'b0011, 32'h8000_0002, 32'h0000_1234, 32'h0000_0000, 32'd0, 2'b00, 0);
    // Simultaneous AW/W, kuseg address passes through.
    awWait = 0; wWait = 0; bWait = 0;
    request(4'b1111, 32'h0000_1008, 32'hA5A5_5A5A, 32'h0000_1008, 32'd0, 2'b00, 0);
    // Read completes while the pipeline is still stalled for 5 cycles.
    arWait = 0; rWait = 0;
    request(4'b0000, 32'h9000_0010, 32'd0, 32'h1000_0010, 32'h1234_5678, 2'b00, 5);
    // Read with waits and SLVERR.
    arWait = 1; rWait = 2;
    request(4'b0000, 32'h8000_0100, 32'd0, 32'h0000_0100, 32'hCAFE_F00D, 2'b10, 0);
    // Write with W first, slow B, DECERR.
    awWait = 3; wWait = 0; bWait = 2;
    request(4'b1100, 32'h0000_2006, 32'hABCD_0000, 32'h0000_2004, 32'd0, 2'b11, 2);

    // Reset asserted while waiting in RDATA.
    arWait = 0; rWait = 30; slvRdata = 32'h0BAD_0BAD; slvResp = 2'b00;
    arQ.push_back(32'h0000_0040); rdQ.push_back(32'h0BAD_0BAD); errQ.push_back(1'b0);
    data_en = 1'b1; data_wen = 4'd0; data_addr = 32'hA000_0040; longest_stall = 1'b1;
    for (int c = 0; c < 10 && !rready; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_rdata", rready, 1);
    data_en = 1'b0;
    #1; resetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_dstall", d_stall, 0);
    chk("mid_rst_rdata", data_rdata, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    arQ.delete(); rdQ.delete(); errQ.delete();
    longest_stall = 1'b0;
    #1; data_en = 1'b1;
    #1; chk("post_rst_idle", d_stall, 1);
    chk("post_rst_arvalid", arvalid, 0);
    data_en = 1'b0;
    @(posedge clk); #1;

    // Recovery read after the abandoned transaction.
    arWait = 1; rWait = 1;
    request(4'b0000, 32'hBFC0_0000, 32'd0, 32'h1FC0_0000, 32'h5555_AAAA, 2'b00, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_axi_bridge.md
Name: data_axi_bridge

Overview:
- Converts the core's data-side SRAM-like memory-stage request (enable, byte write-enable, address, write data) into single-beat AXI4 master transactions.
- Returns read data to the writeback register path and generates the d_stall input to the hazard unit.
- Sits between the pipeline core and the SoC AXI crossbar, beside the instruction-side bridge.
- Supports one outstanding transaction, no bursts and no cache.

Parameters:
- KSEG_MAP, 1, when 1 map kseg0/kseg1 virtual addresses (top bits 3'b100 / 3'b101) to physical by clearing addr[31:29]; when 0 pass the address through unchanged.
- RESP_CHECK, 1, when 1 raise bus_err on a non-OKAY rresp/bresp.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_en  in  1  memory-stage access request; already masked by exception/flush.
- data_wen  in  4  byte write strobes; 0 means read.
- data_addr  in  32  virtual byte address from aluoutM.
- data_wdata  in  32  byte-lane-aligned store data.
- data_rdata  out  32  full read word, before ReadData_handle.
- longest_stall  in  1  global pipeline stall, from the hazard unit.
- d_stall  out  1  data-side stall request.
- bus_err  out  1  one-cycle pulse on an error response.
- araddr  out  32  AXI read address, word-aligned physical.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read data.
- rresp  in  2  read response.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- awaddr  out  32  write address, word-aligned physical.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  32  write data.
- wstrb  out  4  write strobes, equal to data_wen.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  2  write response.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Fixed AXI fields are tied off in the top-level wrapper, not in this block: id=1, len=0, size=3'b010, burst=INCR, lock/cache/prot=0, wlast=1.

Behaviour:
- Reset (resetn=0, async): state=IDLE; arvalid, rready, awvalid, wvalid, bready, bus_err all 0; data_rdata=0; address/data/strobe registers 0.
- d_stall = data_en & (state != DONE). This is combinational, so a request stalls in the same cycle it appears.
- IDLE: on data_en, capture the mapped address {pa[31:2],2'b00}, wdata and wen.
  - If wen==0, go to RADDR.
  - Otherwise go to WREQ, with aw_done=0 and w_done=0.
- RADDR: arvalid=1, held stable until arready. On arvalid&arready go to RDATA.
- RDATA: rready=1. On rvalid, register rdata into data_rdata and go to DONE.
- WREQ: awvalid=~aw_done and wvalid=~w_done, driven independently.
  - aw_done sets on awvalid&awready; w_done sets on wvalid&wready.
  - Both handshakes in the same cycle are legal.
  - When both are done (including the cycle the second completes), go to WRESP.
- WRESP: bready=1. On bvalid go to DONE.
- DONE: d_stall=0 and data_rdata is held.
  - Stay while longest_stall=1 (e.g. i_stall still active). This prevents reissuing the same held request.
  - On longest_stall=0 the pipeline advances; go to IDLE.
- Minimum latency:
  - Read: 4 cycles request→DONE (IDLE, RADDR, RDATA, DONE) with zero-wait slave.
  - Write: 4 cycles (IDLE, WREQ, WRESP, DONE).
- bus_err: registered pulse in the cycle after rvalid/bvalid, only if resp!=2'b00 and RESP_CHECK=1. The transaction still completes normally.
- data_en dropping mid-transaction (flush): the AXI transaction still completes, then waits in DONE as normal. Valids are never withdrawn once asserted.
- Reset mid-transaction is the only permitted case of abandoning a handshake.
- data_wen/data_addr changes while state!=IDLE are ignored; captured copies are used.

Decomposition:
- Shared package axi_defs: state encoding (IDLE, RADDR, RDATA, WREQ, WRESP, DONE), AXI response codes (OKAY=2'b00), fixed id/size/burst constants.
- One natural sub-module: kseg_map, a combinational virtual-to-physical address mapper. The instruction-side bridge reuses it.

Test Plan:
- Read, zero-wait slave: data_en=1, wen=0, addr=0xBFC0_0104, slave returns 0xDEADBEEF → araddr=0x1FC0_0104, d_stall high 3 cycles, data_rdata=0xDEADBEEF in DONE.
- Write, aw before w: wen=4'b0011, addr=0x8000_0002, wdata=0x0000_1234; awready cycle 1, wready cycle 3 → awaddr=0x0000_0000, wstrb=0011, single bready, returns to IDLE after longest_stall=0.
- Simultaneous aw/w handshake in one cycle → exactly one aw and one w beat, goes directly to WRESP.
- DONE hold: read completes while longest_stall=1 for 5 cycles → no second arvalid, data_rdata stable, IDLE one cycle after longest_stall falls.
- Error response: rresp=2'b10 → bus_err pulses exactly 1 cycle, data_rdata updated, d_stall released.
- Async reset asserted during RDATA → all valids/readies and d_stall (with data_en=0) drop immediately; state=IDLE after release.
